uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL provide parameter: CLKS_PER_BIT, 16, clk cycles per serial bit (legal range >=4, even).
REQ-002 SHALL provide port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL provide port: rst  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
REQ-004 SHALL provide port: rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL provide port: sel  input  2  parity select: 00 none, 01 odd, 10 even, 11 none.
REQ-006 SHALL provide port: data_out  output  8  last received byte.
REQ-007 SHALL provide port: rx_done  output  1  one-cycle pulse when a frame completes.
REQ-008 SHALL provide port: pb_error  output  1  parity mismatch on last frame.
REQ-009 SHALL provide port: sb_error  output  1  stop bit sampled low on last frame.
REQ-010 SHALL provide port: busy  output  1  high while the FSM is not in IDLE.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: a high-to-low transition of rx_s -> START, bit counter cleared, sel captured into an internal register for the whole frame.
REQ-014 START: after CLKS_PER_BIT/2 cycles, sample rx_s; low -> DATA; high -> IDLE (false start, no rx_done, errors unchanged).
REQ-015 DATA: sample every CLKS_PER_BIT cycles at bit centre, LSB first, 8 bits; then -> PARITY if captured sel is 01/10, else -> STOP.
REQ-016 PARITY: sample one bit; odd: error if XOR(data, bit) != 1; even: error if XOR(data, bit) != 0.
REQ-017 STOP: sample one bit at centre; sb_error = ~sample; pb_error = parity result, or 0 if no parity.
REQ-018 On the cycle after the stop sample: data_out, pb_error, sb_error update together, rx_done pulses for exactly one cycle, FSM -> IDLE.
REQ-019 data_out, pb_error, sb_error SHALL hold their values until the next rx_done.
REQ-020 Data SHALL be delivered even when pb_error or sb_error is set.
REQ-021 Line held low through the stop bit (break): sb_error=1; no new frame starts until rx_s returns high and falls again.
REQ-022 Changes on sel during a frame SHALL NOT affect that frame.
REQ-023 Baud counter width SHALL be $clog2(CLKS_PER_BIT); counter wraps to 0 on each sample.

Reset
REQ-024 When rst=0 at a rising clk edge: FSM -> IDLE, counters 0, data_out=8'h00, rx_done=0, pb_error=0, sb_error=0, busy=0, synchronizer flops = 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no rx_done; a partial byte SHALL never reach data_out.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: sel behaves per REQ-005/016.
REQ-027 Macro UART_RX_PARITY_EN undefined: PARITY state and parity logic SHALL be absent, sel ignored, every frame is 8N1, pb_error tied 0.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state enumeration, sel encodings (PAR_NONE, PAR_ODD, PAR_EVEN) and default CLKS_PER_BIT, for reuse by the transmitter.
REQ-029 Synchronizer SHALL be a sub-module uart_sync2 (1-bit, two flops, reset value 1); all other logic stays in uart_receiver.

Verification (CLKS_PER_BIT=16, UART_RX_PARITY_EN defined)
REQ-030 sel=10, frame start/8'h15 LSB-first/parity 1/stop 1 -> data_out=8'h15, one rx_done pulse, pb_error=0, sb_error=0.
REQ-031 sel=10, 8'h15 with parity bit 0 -> data_out=8'h15, pb_error=1, sb_error=0.
REQ-032 sel=00, 8'hA5 no parity bit, stop 0 -> data_out=8'hA5, sb_error=1, pb_error=0; next valid frame 8'h3C clears sb_error.
REQ-033 rx low glitch of 4 cycles in IDLE -> no rx_done, busy returns 0 within CLKS_PER_BIT/2+3 cycles, outputs unchanged.
REQ-034 rst=0 for one cycle during DATA bit 4 of 8'hFF -> no rx_done, data_out stays 8'h00; following frame 8'h5A (sel=01, parity 1) received with no errors.
REQ-035 Macro undefined, sel=10, 8'h15 sent as 8N1 -> data_out=8'h15, pb_error=0, sb_error=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity select codes and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 1 (idle line level).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start/8 data/optional parity/stop, sampled at bit centre from a synchronized line.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined; otherwise every frame is 8N1.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] sel,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       pb_error,
  output logic       sb_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          sb_q, sb_d;
  logic          done_d;
  logic          rx_s;
  logic          rx_prev;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic [1:0] mode_q, mode_d;
  logic       par_err_q, par_err_d;
  logic       pb_q, pb_d;
`else
  logic unused_sel;
  assign unused_sel = ^sel;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      sb_q      <= 1'b0;
      rx_done   <= 1'b0;
      rx_prev   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      mode_q    <= PAR_NONE;
      par_err_q <= 1'b0;
      pb_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      sb_q      <= sb_d;
      rx_done   <= done_d;
      rx_prev   <= rx_s;
`ifdef UART_RX_PARITY_EN
      mode_q    <= mode_d;
      par_err_q <= par_err_d;
      pb_q      <= pb_d;
`endif
    end
  end

  // Counter restarts at every sample so each sample lands one bit period after the last.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    sb_d      = sb_q;
    done_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    mode_d    = mode_q;
    par_err_d = par_err_q;
    pb_d      = pb_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d   = START;
          cnt_d     = '0;
          bit_d     = '0;
`ifdef UART_RX_PARITY_EN
          mode_d    = sel;
          par_err_d = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = (mode_q == PAR_ODD || mode_q == PAR_EVEN) ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d     = '0;
          par_err_d = (mode_q == PAR_ODD) ? ~(^shift_q ^ rx_s) : (^shift_q ^ rx_s);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          data_d  = shift_q;
          sb_d    = ~rx_s;
`ifdef UART_RX_PARITY_EN
          pb_d    = par_err_q;
`endif
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out = data_q;
  assign sb_error = sb_q;
  assign busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign pb_error = pb_q;
`else
  assign pb_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected results, a monitor checks each rx_done.
`timescale 1ns/1ps
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [1:0] sel = PAR_NONE;
  logic [7:0] data_out;
  logic       rx_done;
  logic       pb_error;
  logic       sb_error;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       pb;
    logic       sb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .sel      (sel),
    .data_out (data_out),
    .rx_done  (rx_done),
    .pb_error (pb_error),
    .sb_error (sb_error),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pb, input logic sb);
    exp_t e;
    e.data = d;
    e.pb   = pb;
    e.sb   = sb;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // One full frame; sel switches to sel_mid after the start bit so mid-frame changes can be exercised.
  task automatic apply_stimulus(input logic [7:0] d, input logic has_par, input logic par_bit,
                                input logic stop_bit, input logic [1:0] sel_mid);
    send_bit(1'b0);
    sel = sel_mid;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(par_bit);
    send_bit(stop_bit);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    logic last_done;
    last_done = 1'b0;
    forever begin
      @(negedge clk);
      if (last_done) check_output("rx_done_width", {7'd0, rx_done}, 8'd0);
      if (rx_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rx_done actual data=%0h expected no frame", data_out);
        end else begin
          e = exp_q.pop_front();
          check_output("data_out", data_out, e.data);
          check_output("pb_error", {7'd0, pb_error}, {7'd0, e.pb});
          check_output("sb_error", {7'd0, sb_error}, {7'd0, e.sb});
        end
      end
      last_done = rx_done;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int waited;
    repeat (3) @(negedge clk);
    check_output("reset_data_out", data_out, 8'h00);
    check_output("reset_rx_done", {7'd0, rx_done}, 8'd0);
    check_output("reset_pb_error", {7'd0, pb_error}, 8'd0);
    check_output("reset_sb_error", {7'd0, sb_error}, 8'd0);
    check_output("reset_busy", {7'd0, busy}, 8'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    sel = PAR_EVEN;
    push_exp(8'h15, 1'b0, 1'b0);
    apply_stimulus(8'h15, 1'b1, 1'b1, 1'b1, PAR_EVEN);
    push_exp(8'h15, 1'b1, 1'b0);
    apply_stimulus(8'h15, 1'b1, 1'b0, 1'b1, PAR_EVEN);
    sel = PAR_NONE;
    push_exp(8'hA5, 1'b0, 1'b1);
    apply_stimulus(8'hA5, 1'b0, 1'b0, 1'b0, PAR_NONE);
    push_exp(8'h15, 1'b1, 1'b0);
    sel = PAR_EVEN;
    apply_stimulus(8'h15, 1'b1, 1'b0, 1'b1, PAR_NONE);
    push_exp(8'h3C, 1'b0, 1'b0);
    apply_stimulus(8'h3C, 1'b0, 1'b0, 1'b1, PAR_NONE);
`else
    sel = PAR_EVEN;
    push_exp(8'h15, 1'b0, 1'b0);
    apply_stimulus(8'h15, 1'b0, 1'b0, 1'b1, PAR_EVEN);
    sel = PAR_NONE;
    push_exp(8'hA5, 1'b0, 1'b1);
    apply_stimulus(8'hA5, 1'b0, 1'b0, 1'b0, PAR_NONE);
    push_exp(8'h3C, 1'b0, 1'b0);
    apply_stimulus(8'h3C, 1'b0, 1'b0, 1'b1, PAR_NONE);
`endif

    // Short low glitch: receiver must enter START, reject it, and leave outputs alone.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check_output("glitch_busy_high", {7'd0, busy}, 8'd1);
    rx = 1'b1;
    waited = 0;
    while (busy && waited < CPB / 2 + 3) begin
      @(negedge clk);
      waited++;
    end
    check_output("glitch_busy_low", {7'd0, busy}, 8'd0);
    check_output("glitch_data_out", data_out, 8'h3C);
    check_output("glitch_sb_error", {7'd0, sb_error}, 8'd0);
    check_output("glitch_pb_error", {7'd0, pb_error}, 8'd0);

    // Reset in the middle of data bit 4 of 8'hFF aborts the frame.
    sel = PAR_NONE;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_output("abort_busy", {7'd0, busy}, 8'd0);
    check_output("abort_data_out", data_out, 8'h00);
    repeat (5 * CPB) @(negedge clk);
    check_output("abort_data_hold", data_out, 8'h00);
    check_output("abort_idle", {7'd0, busy}, 8'd0);

`ifdef UART_RX_PARITY_EN
    sel = PAR_ODD;
    push_exp(8'h5A, 1'b0, 1'b0);
    apply_stimulus(8'h5A, 1'b1, 1'b1, 1'b1, PAR_ODD);
`else
    push_exp(8'h5A, 1'b0, 1'b0);
    apply_stimulus(8'h5A, 1'b0, 1'b0, 1'b1, PAR_NONE);
`endif

    waited = 0;
    while (exp_q.size() != 0 && waited < 4 * CPB) begin
      @(negedge clk);
      waited++;
    end
    check_output("frames_outstanding", 8'(exp_q.size()), 8'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
